// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants and the write-enable decoder used by the
// writeback arbiter.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  // x0 is hardwired to zero, so its enable bit is never set.
  function automatic logic [NREG-1:0] onehot_dec(input logic [REG_ADDR_W-1:0] rd);
    logic [NREG-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    m[0]  = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last accepted requester, and
// the pointer moves only when the winner's transfer is actually accepted.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    advance_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] last_grant_q;
  logic [IW-1:0] last_grant_d;

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

  assign last_grant_d = advance_i ? idx_o : last_grant_q;

  // Reset value makes requester 0 the first one searched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_grant_q <= IW'(NREQ - 1);
    else         last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among writeback requesters and registers
// the committed write as one-hot load enables plus a common data bus.
module rf_write_arbiter
  import rv32_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*5-1:0]       req_rd,
  input  logic [NREQ*XLEN-1:0]    req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    hold,
  output logic [NREG-1:0]         rf_load_en,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [CNT_W-1:0]        conflict_cnt
);

  localparam int GID_W = $clog2(NREQ);

  logic [NREQ-1:0]       grant;
  logic [GID_W-1:0]      grant_idx;
  logic                  accept;
  logic                  contention;
  logic [4:0]            rd_arr   [NREQ];
  logic [XLEN-1:0]       data_arr [NREQ];

  logic [NREG-1:0]  rf_load_en_q,   rf_load_en_d;
  logic [XLEN-1:0]  rf_wdata_q,     rf_wdata_d;
  logic             wb_valid_q,     wb_valid_d;
  logic [4:0]       wb_rd_q,        wb_rd_d;
  logic [GID_W-1:0] grant_id_q,     grant_id_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rd_arr[g]   = req_rd[g*5 +: 5];
    assign data_arr[g] = req_data[g*XLEN +: XLEN];
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk_i     (clk),
    .rst_ni    (rst),
    .req_i     (req_valid),
    .advance_i (accept),
    .grant_o   (grant),
    .idx_o     (grant_idx)
  );

  assign req_ready  = grant & {NREQ{~hold}};
  assign accept     = |(req_valid & req_ready);
  assign contention = ~hold && ($countones(req_valid) >= 2);

  // Data-side registers hold their value when nothing is accepted.
  always_comb begin
    rf_load_en_d   = '0;
    wb_valid_d     = accept;
    rf_wdata_d     = rf_wdata_q;
    wb_rd_d        = wb_rd_q;
    grant_id_d     = grant_id_q;
    conflict_cnt_d = conflict_cnt_q;
    if (accept) begin
      rf_load_en_d = NREG'(onehot_dec(rd_arr[grant_idx]));
      rf_wdata_d   = data_arr[grant_idx];
      wb_rd_d      = rd_arr[grant_idx];
      grant_id_d   = grant_idx;
    end
    if (contention && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_load_en_q   <= '0;
      rf_wdata_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      grant_id_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rf_load_en_q   <= rf_load_en_d;
      rf_wdata_q     <= rf_wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      grant_id_q     <= grant_id_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign rf_load_en   = rf_load_en_q;
  assign rf_wdata     = rf_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign grant_id     = grant_id_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for the writeback arbiter; the contention counter is narrowed
// so saturation is reachable in a few cycles.
module tb_rf_write_arbiter;

  localparam int NREQ  = 2;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 hold;
  logic [NREG-1:0]      rf_load_en;
  logic [XLEN-1:0]      rf_wdata;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic [0:0]           grant_id;
  logic [CNT_W-1:0]     conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  rf_write_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .hold         (hold),
    .rf_load_en   (rf_load_en),
    .rf_wdata     (rf_wdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic [4:0] rd1, input logic [31:0] d1);
    req_valid = v;
    req_rd    = {rd1, rd0};
    req_data  = {d1, d0};
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
  endtask

  initial begin
    logic [4:0]  exp_rd;
    logic [31:0] exp_d;
    rst  = 1'b0;
    hold = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    step();
    check_vec("rst_load_en", rf_load_en, 32'h0);
    check_vec("rst_cnt", 32'(conflict_cnt), 32'h0);
    rst = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 10; i++) begin
      step();
      check_vec("idle_load_en", rf_load_en, 32'h0);
      check_vec("idle_outs", {25'd0, wb_valid, wb_rd, grant_id}, 32'h0);
      check_vec("idle_wdata", rf_wdata, 32'h0);
      check_vec("idle_ready", 32'(req_ready), 32'h0);
    end

    // Single ALU write
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    #1 check_vec("alu_ready", 32'(req_ready), 32'h1);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check_vec("alu_load_en", rf_load_en, 32'h0000_0020);
    check_vec("alu_wdata", rf_wdata, 32'hDEADBEEF);
    check_vec("alu_wb_valid", 32'(wb_valid), 32'h1);
    check_vec("alu_grant", 32'(grant_id), 32'h0);
    check_vec("alu_wb_rd", 32'(wb_rd), 32'd5);
    step();
    check_vec("alu_pulse_end", rf_load_en, 32'h0);
    check_vec("alu_valid_end", 32'(wb_valid), 32'h0);
    check_vec("alu_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // Two requesters, each drops after acceptance
    pulse_reset();
    drive(2'b11, 5'd3, 32'h0000_0333, 5'd7, 32'h0000_0777);
    #1 check_vec("both_ready0", 32'(req_ready), 32'h1);
    step();
    drive(2'b10, 5'd3, 32'h0000_0333, 5'd7, 32'h0000_0777);
    check_vec("both_load0", rf_load_en, 32'h0000_0008);
    check_vec("both_gid0", 32'(grant_id), 32'h0);
    #1 check_vec("both_ready1", 32'(req_ready), 32'h2);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check_vec("both_load1", rf_load_en, 32'h0000_0080);
    check_vec("both_gid1", 32'(grant_id), 32'h1);
    check_vec("both_wdata1", rf_wdata, 32'h0000_0777);
    step();
    check_vec("both_cnt", 32'(conflict_cnt), 32'h1);
    check_vec("both_idle", rf_load_en, 32'h0);

    // Persistent contention, fresh data each cycle
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 5'(1 + k), 32'hA000_0000 + k, 5'(16 + k), 32'hB000_0000 + k);
      #1 check_vec("cont_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      exp_rd = (k % 2 == 0) ? 5'(1 + k) : 5'(16 + k);
      exp_d  = (k % 2 == 0) ? 32'hA000_0000 + k : 32'hB000_0000 + k;
      check_vec("cont_gid", 32'(grant_id), 32'(k % 2));
      check_vec("cont_load", rf_load_en, 32'h1 << exp_rd);
      check_vec("cont_wdata", rf_wdata, exp_d);
    end
    check_vec("cont_cnt6", 32'(conflict_cnt), 32'd6);

    // Counter saturates at all-ones
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 5'd2, 32'h0, 5'd4, 32'h0);
      step();
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check_vec("sat_cnt", 32'(conflict_cnt), 32'd7);

    // Write to x0 is accepted but enables nothing
    drive(2'b10, 5'd0, 32'h0, 5'd0, 32'h12345678);
    #1 check_vec("x0_ready", 32'(req_ready), 32'h2);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check_vec("x0_wb_valid", 32'(wb_valid), 32'h1);
    check_vec("x0_wb_rd", 32'(wb_rd), 32'h0);
    check_vec("x0_load_en", rf_load_en, 32'h0);
    check_vec("x0_wdata", rf_wdata, 32'h12345678);
    check_vec("x0_gid", 32'(grant_id), 32'h1);
    check_vec("x0_cnt", 32'(conflict_cnt), 32'd7);

    // Hold freezes acceptance and counting
    hold = 1'b1;
    drive(2'b01, 5'd9, 32'h55AA55AA, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1 check_vec("hold_ready", 32'(req_ready), 32'h0);
      step();
      check_vec("hold_load_en", rf_load_en, 32'h0);
      check_vec("hold_wb_valid", 32'(wb_valid), 32'h0);
    end
    hold = 1'b0;
    #1 check_vec("unhold_ready", 32'(req_ready), 32'h1);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    check_vec("unhold_load_en", rf_load_en, 32'h0000_0200);
    check_vec("unhold_wb_valid", 32'(wb_valid), 32'h1);

    // Asynchronous reset during the commit cycle
    #1 rst = 1'b0;
    #1;
    check_vec("mid_rst_load_en", rf_load_en, 32'h0);
    check_vec("mid_rst_wb_valid", 32'(wb_valid), 32'h0);
    check_vec("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
    check_vec("mid_rst_wdata", rf_wdata, 32'h0);
    rst = 1'b1;
    step();
    check_vec("post_rst_load_en", rf_load_en, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
